// File: rtl/nn_isa_pkg.sv
// Shared ISA definitions for the NN processor: opcodes, instruction field
// positions, opcode legality check and the fetch/issue state encoding.
package nn_isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_MAC  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_ST   = 4'hF;

  // Field bit positions within a 16-bit instruction word
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 0;
  localparam int FLD_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } fetch_state_e;

  function automatic logic is_defined_opcode(input logic [3:0] op);
    case (op)
      OP_NOP, OP_ADD, OP_MUL, OP_SLT, OP_MAC,
      OP_ADDI, OP_HALT, OP_LD, OP_ST: is_defined_opcode = 1'b1;
      default:                        is_defined_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_issue.sv
// Instruction fetch-and-issue unit: steps a PC through a synchronous
// instruction memory, splits each word into fields and hands them to the
// control unit over a valid/ready handshake. HALT is consumed here; an
// undefined opcode stops the unit and raises a sticky error.
module instr_fetch_issue
  import nn_isa_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [3:0]         opcode,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               err_q, err_d;
  logic [3:0]         rdata_op;

  assign rdata_op = imem_rdata[OPC_LSB +: FLD_W];

  // State, PC, instruction register and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; start is only honoured when not already running
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        ir_d = imem_rdata;
        if (rdata_op == OP_HALT) begin
          state_d = S_HALTED;
        end else if (!is_defined_opcode(rdata_op)) begin
          err_d   = 1'b1;
          state_d = S_HALTED;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come only from registers or the state decode, so issue_ready
  // never reaches an output combinationally.
  assign imem_addr   = pc_q;
  assign imem_rd_en  = (state_q == S_FETCH);
  assign issue_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALTED);
  assign error       = err_q;
  assign opcode      = ir_q[OPC_LSB +: FLD_W];
  assign rd          = ir_q[RD_LSB  +: FLD_W];
  assign rs          = ir_q[RS_LSB  +: FLD_W];
  assign rt          = ir_q[RT_LSB  +: FLD_W];
  assign pc_out      = pc_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Scoreboard bench for instr_fetch_issue: directed programs push expected
// issues into a queue, a negedge monitor checks every presented issue.
// A second, 2-bit-address instance covers PC wraparound.
module tb_instr_fetch_issue;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b1;
  logic [3:0]  opcode, rd, rs, rt;
  logic [7:0]  pc_out;
  logic        busy, halted, error;

  logic        reset2 = 1'b1;
  logic        start2 = 1'b0;
  logic [1:0]  imem_addr2;
  logic        imem_rd_en2;
  logic [15:0] imem_rdata2 = '0;
  logic        issue_valid2;
  logic        issue_ready2 = 1'b1;
  logic [3:0]  opcode2, rd2, rs2, rt2;
  logic [1:0]  pc_out2;
  logic        busy2, halted2, error2;

  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];

  exp_t sb[$];
  int   sb2[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  instr_fetch_issue #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .pc_out(pc_out),
    .busy(busy), .halted(halted), .error(error)
  );

  instr_fetch_issue #(.ADDR_W(2), .INSTR_W(16)) dut2 (
    .clk(clk), .reset(reset2), .start(start2),
    .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2), .imem_rdata(imem_rdata2),
    .issue_valid(issue_valid2), .issue_ready(issue_ready2),
    .opcode(opcode2), .rd(rd2), .rs(rs2), .rt(rt2), .pc_out(pc_out2),
    .busy(busy2), .halted(halted2), .error(error2)
  );

  // Synchronous instruction memories, one-cycle read latency
  always @(posedge clk) begin
    if (imem_rd_en)  imem_rdata  <= mem[imem_addr];
    if (imem_rd_en2) imem_rdata2 <= mem2[imem_addr2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented issue must match the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (!reset && issue_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got op %0h pc %0h expected none", opcode, pc_out);
      end else begin
        chk("opcode", 32'(opcode), 32'(sb[0].op));
        chk("rd",     32'(rd),     32'(sb[0].rd));
        chk("rs",     32'(rs),     32'(sb[0].rs));
        chk("rt",     32'(rt),     32'(sb[0].rt));
        chk("pc_out", 32'(pc_out), 32'(sb[0].pc));
        if (issue_ready) void'(sb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset2 && issue_valid2 && sb2.size() > 0) begin
      chk("wrap_pc", 32'(pc_out2), 32'(sb2[0]));
      chk("wrap_op", 32'(opcode2), 32'h0);
      if (issue_ready2) void'(sb2.pop_front());
    end
  end

  function automatic exp_t mk(input logic [15:0] w, input logic [7:0] pc);
    mk = '{op: w[15:12], rd: w[11:8], rs: w[7:4], rt: w[3:0], pc: pc};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Returns one cycle into FETCH (cycle 1 relative to the start sample)
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_halted(input string nm);
    for (int i = 0; i < 40; i++) begin
      if (halted) break;
      step();
    end
    chk(nm, 32'(halted), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++)   mem2[i] = 16'h0000;

    // Reset state
    step();
    chk("rst_outs", {busy, halted, error, issue_valid, imem_rd_en}, 32'h0);
    chk("rst_flds", {opcode, rd, rs, rt, pc_out, imem_addr}, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'h0);

    // Basic program, ready high: issues at cycles 3 and 6, halted at 9
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'hB000;
    issue_ready = 1'b1;
    sb.push_back(mk(16'h1123, 8'd0));
    sb.push_back(mk(16'h2456, 8'd1));
    pulse_start();
    chk("c1_fetch", {busy, imem_rd_en, imem_addr}, {22'h0, 1'b1, 1'b1, 8'h00});
    step(); chk("c2_valid", 32'(issue_valid), 32'h0);
    step(); chk("c3_valid", 32'(issue_valid), 32'h1);
    step(); chk("c4_valid", 32'(issue_valid), 32'h0);
    step(); step(); chk("c6_valid", 32'(issue_valid), 32'h1);
    step(); step(); chk("c8_halted", 32'(halted), 32'h0);
    step(); chk("c9_halted", 32'(halted), 32'h1);
    chk("halt_pc", 32'(pc_out), 32'h2);
    chk("halt_busy", 32'(busy), 32'h0);
    chk("sb_empty1", 32'(sb.size()), 32'h0);
    step(); step(); chk("halt_pc_hold", 32'(pc_out), 32'h2);

    // Backpressure: ready low through 4 ISSUE cycles
    mem[0] = 16'h3789; mem[1] = 16'hB000;
    issue_ready = 1'b0;
    sb.push_back(mk(16'h3789, 8'd0));
    pulse_start();
    step(); step();
    chk("bp_valid", 32'(issue_valid), 32'h1);
    step(); step(); step();
    chk("bp_nofetch", 32'(imem_rd_en), 32'h0);
    step();
    chk("bp_still_valid", 32'(issue_valid), 32'h1);
    issue_ready = 1'b1;
    step();
    chk("bp_fetch1", {imem_rd_en, imem_addr}, {23'h0, 1'b1, 8'h01});
    wait_halted("bp_halt");
    chk("sb_empty2", 32'(sb.size()), 32'h0);

    // Undefined opcode stops with error; restart clears it
    mem[0] = 16'h5000;
    pulse_start();
    wait_halted("undef_halt");
    chk("undef_err", 32'(error), 32'h1);
    mem[0] = 16'h4ABC; mem[1] = 16'hB000;
    sb.push_back(mk(16'h4ABC, 8'd0));
    pulse_start();
    chk("restart_err", 32'(error), 32'h0);
    chk("restart_addr", {imem_rd_en, imem_addr}, {23'h0, 1'b1, 8'h00});
    wait_halted("restart_halt");
    chk("restart_err2", 32'(error), 32'h0);
    chk("sb_empty3", 32'(sb.size()), 32'h0);

    // start pulsed during WAIT is ignored
    mem[0] = 16'h9123; mem[1] = 16'hE456; mem[2] = 16'hF789; mem[3] = 16'hB000;
    sb.push_back(mk(16'h9123, 8'd0));
    sb.push_back(mk(16'hE456, 8'd1));
    sb.push_back(mk(16'hF789, 8'd2));
    pulse_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
    chk("wait_start_valid", {issue_valid, pc_out}, {23'h0, 1'b1, 8'h00});
    wait_halted("ws_halt");
    chk("ws_pc", 32'(pc_out), 32'h3);
    chk("sb_empty4", 32'(sb.size()), 32'h0);

    // Asynchronous reset in the middle of ISSUE
    mem[0] = 16'h1111; mem[1] = 16'hB000;
    issue_ready = 1'b0;
    sb.push_back(mk(16'h1111, 8'd0));
    pulse_start();
    step(); step(); step();
    chk("pre_rst_valid", {issue_valid, busy}, 32'h3);
    #1 reset = 1'b1;
    #1 chk("async_rst", {issue_valid, busy, pc_out}, 32'h0);
    @(negedge clk);
    sb.delete();
    step(); reset = 1'b0; issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_idle", {busy, halted, issue_valid}, 32'h0);
    end

    // PC wraparound on a 2-bit address instance
    reset2 = 1'b0;
    for (int p = 0; p < 5; p++) sb2.push_back(p % 4);
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb2.size() == 0) break;
      step();
    end
    chk("wrap_done", 32'(sb2.size()), 32'h0);
    chk("wrap_err", 32'(error2), 32'h0);
    reset2 = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
